vreg_free_list: RTL and testbench
=================================

VREG_FREE_LIST -- requirements
Module: vreg_free_list

Interface
REQ-001 Parameter PREG_COUNT, default 16: number of vector physical registers; power of two, >= 4.
REQ-002 Parameter RESERVED, default 8: registers 0..RESERVED-1, identity-mapped at reset and not free; 1 <= RESERVED < PREG_COUNT.
REQ-003 Derived: W = clog2(PREG_COUNT); count width W+1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 reconfigure  input  1  synchronous restore of reset contents; same cycle as the rename-table reconfigure.
REQ-007 alloc_req  input  1  rename stage requests one free physical register.
REQ-008 alloc_valid  output  1  a free register is available (= ~empty).
REQ-009 alloc_preg  output  W  register granted when alloc_req & alloc_valid; valid whenever alloc_valid=1.
REQ-010 release_en  input  1  commit returns one physical register to the pool.
REQ-011 release_preg  input  W  register being returned.
REQ-012 free_count  output  W+1  number of free registers held.
REQ-013 empty  output  1  free_count == 0.
REQ-014 full  output  1  free_count == PREG_COUNT.
REQ-015 release_err  output  1  one-cycle pulse: illegal release dropped.

Function
REQ-016 Storage: circular FIFO of PREG_COUNT W-bit entries, head/tail pointers of W bits wrapping modulo PREG_COUNT, and a PREG_COUNT-bit is_free bitmap.
REQ-017 alloc_preg = entry at head, combinational from registered state; no same-cycle bypass of a releasing register.
REQ-018 Allocation fires iff alloc_req & alloc_valid: head+1, is_free[alloc_preg] cleared, count-1.
REQ-019 alloc_req while empty: no state change, alloc_valid=0, alloc_preg don't-care.
REQ-020 Release is legal iff release_en & is_free[release_preg]==0 & not full: written at tail, tail+1, is_free set, count+1.
REQ-021 Release of a register already free (double release) or while full: dropped, no state change, release_err=1 next cycle.
REQ-022 Legal release and allocation in the same cycle: both take effect; count unchanged; head and tail each advance.
REQ-023 Same-cycle release of the register currently at head while it is being allocated is impossible by construction (is_free set) and is flagged per REQ-021.
REQ-024 reconfigure has priority over alloc and release in the same cycle; both are ignored and the FIFO is reloaded per REQ-026.
REQ-025 release_err is registered; it is deasserted in any cycle following a cycle with no illegal release.

Reset
REQ-026 Reset (rst_n=0, asynchronous) and reconfigure (synchronous) both produce: entries 0..PREG_COUNT-RESERVED-1 hold RESERVED..PREG_COUNT-1 ascending; head=0; tail=PREG_COUNT-RESERVED (mod PREG_COUNT); is_free[i]=1 iff i>=RESERVED; release_err=0.
REQ-027 Output values after reset with defaults: free_count=8, alloc_valid=1, alloc_preg=8, empty=0, full=0, release_err=0.
REQ-028 rst_n asserted mid-operation discards all pending allocations and releases immediately; no partial update survives.

Verification
REQ-029 Reset, then alloc_req held 8 cycles -> alloc_preg 8,9,...,15 in order; after the 8th, empty=1, alloc_valid=0, free_count=0; 9th request has no effect.
REQ-030 From empty, release 3 then 12 -> free_count=2; next two allocations return 3 then 12 (FIFO order).
REQ-031 free_count=5, simultaneous alloc_req and legal release of 2 -> free_count stays 5, granted register = previous head, 2 appended at tail.
REQ-032 After reset, release_preg=9 (already free) -> release_err=1 for one cycle, free_count stays 8; releasing 0 (reserved, not free) -> accepted, free_count=9.
REQ-033 Release all 16 so full=1, then release any register -> release_err=1, full stays 1; wrap-around of tail across index 15->0 exercised.
REQ-034 Mid-stream reconfigure asserted together with alloc_req and release_en -> next cycle state equals REQ-027 values; neither request takes effect.

Source files
------------

// File: rtl/vreg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : vreg_free_list
// Brief    : FIFO free list of vector physical registers with is_free bitmap.
// Revision : 1.0 - initial release
// ============================================================================
module vreg_free_list #(
   parameter int PREG_COUNT = 16,
   parameter int RESERVED   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          reconfigure,
   input  logic                          alloc_req,
   output logic                          alloc_valid,
   output logic [$clog2(PREG_COUNT)-1:0] alloc_preg,
   input  logic                          release_en,
   input  logic [$clog2(PREG_COUNT)-1:0] release_preg,
   output logic [$clog2(PREG_COUNT):0]   free_count,
   output logic                          empty,
   output logic                          full,
   output logic                          release_err
);

   localparam int c_W  = $clog2(PREG_COUNT);
   localparam int c_CW = c_W + 1;
   localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(PREG_COUNT);
   localparam logic [c_CW-1:0] c_INIT_COUNT = c_CW'(PREG_COUNT - RESERVED);
   localparam logic [c_W-1:0]  c_INIT_TAIL  = c_W'(PREG_COUNT - RESERVED);

   logic [c_W-1:0]        r_fifo [PREG_COUNT];
   logic [c_W-1:0]        r_head;
   logic [c_W-1:0]        r_tail;
   logic [c_CW-1:0]       r_count;
   logic [PREG_COUNT-1:0] r_is_free;
   logic                  r_release_err;

   logic [c_W-1:0]        w_init_fifo [PREG_COUNT];
   logic [PREG_COUNT-1:0] w_init_free;
   logic [PREG_COUNT-1:0] w_next_free;
   logic                  w_alloc;
   logic                  w_rel_ok;
   logic                  w_rel_bad;

   // Reset image: non-reserved registers queued in ascending order.
   for (genvar i = 0; i < PREG_COUNT; i++) begin : g_init
      assign w_init_fifo[i] = (i < PREG_COUNT - RESERVED) ? c_W'(i + RESERVED) : '0;
      assign w_init_free[i] = (i >= RESERVED);
   end

   assign alloc_valid = (r_count != '0);
   assign alloc_preg  = r_fifo[r_head];
   assign free_count  = r_count;
   assign empty       = (r_count == '0);
   assign full        = (r_count == c_FULL_COUNT);
   assign release_err = r_release_err;

   assign w_alloc   = alloc_req & alloc_valid;
   assign w_rel_ok  = release_en & ~r_is_free[release_preg] & ~full;
   assign w_rel_bad = release_en & ~w_rel_ok;

   // The granted and released registers never coincide: a granted one is free,
   // so releasing it is illegal.
   always_comb begin
      w_next_free = r_is_free;
      if (w_alloc)
         w_next_free[alloc_preg] = 1'b0;
      if (w_rel_ok)
         w_next_free[release_preg] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo        <= w_init_fifo;
         r_head        <= '0;
         r_tail        <= c_INIT_TAIL;
         r_count       <= c_INIT_COUNT;
         r_is_free     <= w_init_free;
         r_release_err <= 1'b0;
      end else if (reconfigure) begin
         r_fifo        <= w_init_fifo;
         r_head        <= '0;
         r_tail        <= c_INIT_TAIL;
         r_count       <= c_INIT_COUNT;
         r_is_free     <= w_init_free;
         r_release_err <= 1'b0;
      end else begin
         if (w_alloc)
            r_head <= r_head + c_W'(1);
         if (w_rel_ok) begin
            r_fifo[r_tail] <= release_preg;
            r_tail         <= r_tail + c_W'(1);
         end
         r_is_free     <= w_next_free;
         r_count       <= r_count + c_CW'(w_rel_ok) - c_CW'(w_alloc);
         r_release_err <= w_rel_bad;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vreg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_vreg_free_list
// Brief    : Directed self-checking bench for vreg_free_list (defaults 16/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vreg_free_list;

   logic       clk;
   logic       rst_n;
   logic       reconfigure;
   logic       alloc_req;
   logic       alloc_valid;
   logic [3:0] alloc_preg;
   logic       release_en;
   logic [3:0] release_preg;
   logic [4:0] free_count;
   logic       empty;
   logic       full;
   logic       release_err;

   int n_checks;
   int n_fail;

   vreg_free_list #(.PREG_COUNT(16), .RESERVED(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .reconfigure  (reconfigure),
      .alloc_req    (alloc_req),
      .alloc_valid  (alloc_valid),
      .alloc_preg   (alloc_preg),
      .release_en   (release_en),
      .release_preg (release_preg),
      .free_count   (free_count),
      .empty        (empty),
      .full         (full),
      .release_err  (release_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic release_one(input logic [3:0] p);
      release_en   = 1'b1;
      release_preg = p;
      step();
      release_en   = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_count"}, 32'(free_count), 8);
      check({tag, "_valid"}, 32'(alloc_valid), 1);
      check({tag, "_preg"},  32'(alloc_preg), 8);
      check({tag, "_empty"}, 32'(empty), 0);
      check({tag, "_full"},  32'(full), 0);
      check({tag, "_err"},   32'(release_err), 0);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      reconfigure  = 1'b0;
      alloc_req    = 1'b0;
      release_en   = 1'b0;
      release_preg = '0;
      #22 rst_n = 1'b1;
      step();
      check_reset_state("reset");

      // Drain the initial pool: 8..15 in order.
      alloc_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("drain_preg%0d", k), 32'(alloc_preg), 8 + k);
         step();
      end
      check("drain_empty", 32'(empty), 1);
      check("drain_valid", 32'(alloc_valid), 0);
      check("drain_count", 32'(free_count), 0);
      step();
      check("extra_req_count", 32'(free_count), 0);
      check("extra_req_empty", 32'(empty), 1);
      alloc_req = 1'b0;

      // FIFO order of released registers.
      release_one(4'd3);
      release_one(4'd12);
      check("rel2_count", 32'(free_count), 2);
      check("fifo_first", 32'(alloc_preg), 3);
      alloc_req = 1'b1;
      step();
      check("fifo_second", 32'(alloc_preg), 12);
      step();
      alloc_req = 1'b0;
      check("fifo_count0", 32'(free_count), 0);

      // Build count=5 (tail 10..14), then simultaneous alloc + release of 2.
      release_one(4'd1);
      release_one(4'd4);
      release_one(4'd5);
      release_one(4'd6);
      release_one(4'd7);
      check("sim_count_before", 32'(free_count), 5);
      check("sim_head_before", 32'(alloc_preg), 1);
      alloc_req    = 1'b1;
      release_en   = 1'b1;
      release_preg = 4'd2;
      step();
      release_en   = 1'b0;
      check("sim_count_after", 32'(free_count), 5);
      check("sim_err", 32'(release_err), 0);
      begin
         logic [3:0] exp_seq [5];
         exp_seq = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd2};
         for (int k = 0; k < 5; k++) begin
            check($sformatf("sim_seq%0d", k), 32'(alloc_preg), 32'(exp_seq[k]));
            step();
         end
      end
      alloc_req = 1'b0;
      check("sim_drained", 32'(empty), 1);

      // Asynchronous reset mid-operation with requests pending.
      alloc_req    = 1'b1;
      release_en   = 1'b1;
      release_preg = 4'd9;
      rst_n        = 1'b0;
      #3;
      check("async_rst_count", 32'(free_count), 8);
      check("async_rst_preg", 32'(alloc_preg), 8);
      alloc_req  = 1'b0;
      release_en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check_reset_state("rst2");

      // Double release, then release of a reserved register.
      release_one(4'd9);
      check("dbl_err", 32'(release_err), 1);
      check("dbl_count", 32'(free_count), 8);
      release_one(4'd0);
      check("rsv_err_clear", 32'(release_err), 0);
      check("rsv_count", 32'(free_count), 9);

      // Fill to full; tail crosses 15 -> 0.
      for (int p = 1; p < 8; p++)
         release_one(4'(p));
      check("full_flag", 32'(full), 1);
      check("full_count", 32'(free_count), 16);
      release_one(4'd3);
      check("full_err", 32'(release_err), 1);
      check("full_stays", 32'(full), 1);
      step();
      check("full_err_pulse", 32'(release_err), 0);

      // Releasing the register being granted is flagged; allocation still happens.
      alloc_req    = 1'b1;
      release_en   = 1'b1;
      release_preg = 4'd8;
      step();
      release_en = 1'b0;
      check("head_rel_err", 32'(release_err), 1);
      check("head_rel_count", 32'(free_count), 15);
      for (int k = 0; k < 15; k++) begin
         int e;
         e = (k < 7) ? 9 + k : ((k == 7) ? 0 : k - 7);
         check($sformatf("wrap_seq%0d", k), 32'(alloc_preg), 32'(e));
         step();
      end
      alloc_req = 1'b0;
      check("wrap_empty", 32'(empty), 1);

      // Reconfigure beats simultaneous alloc and release.
      release_one(4'd5);
      check("pre_cfg_count", 32'(free_count), 1);
      reconfigure  = 1'b1;
      alloc_req    = 1'b1;
      release_en   = 1'b1;
      release_preg = 4'd6;
      step();
      reconfigure = 1'b0;
      alloc_req   = 1'b0;
      release_en  = 1'b0;
      check_reset_state("cfg");
      alloc_req = 1'b1;
      step();
      alloc_req = 1'b0;
      check("cfg_next_preg", 32'(alloc_preg), 9);
      check("cfg_next_count", 32'(free_count), 7);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
